// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial adder/subtractor: one 8-bit carry-lookahead slice is reused for every
// byte of the operands, LSB byte first, with the carry held in a register between steps.

module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c[7:0];
    cout = c[8];
  end
endmodule

module byte_serial_add_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  input  logic                  i_carry,
  input  logic                  i_sub,
  input  logic                  i_abort,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_carry,
  output logic                  o_overflow,
  output logic                  o_busy,
  output logic [1:0]            o_state
);
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int IDX_W     = $clog2(NUM_BYTES) + 1;

  generate
    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("byte_serial_add_ctrl: DATA_WIDTH must be a multiple of 8 and at least 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] a_sh;
  logic [DATA_WIDTH-1:0] bx_sh;
  logic [DATA_WIDTH-1:0] sum_reg;
  logic [DATA_WIDTH-1:0] sum_shift;
  logic                  carry_reg;
  logic                  carry_out;
  logic                  ovf;
  logic [IDX_W-1:0]      idx;
  logic [7:0]            slice_sum;
  logic                  slice_cout;
  logic                  last_byte;

  // Operands shift right each step, so the active byte always sits in bits [7:0].
  cla_8bit u_slice (
    .a    (a_sh[7:0]),
    .b    (bx_sh[7:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  generate
    if (NUM_BYTES == 1) begin : g_one_byte
      assign sum_shift = slice_sum;
    end else begin : g_multi_byte
      assign sum_shift = {slice_sum, sum_reg[DATA_WIDTH-1:8]};
    end
  endgenerate

  assign last_byte = (idx == IDX_W'(NUM_BYTES - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_valid) state_next = RUN;
      RUN: begin
        if (i_abort)        state_next = IDLE;
        else if (last_byte) state_next = DONE;
      end
      DONE: if (i_abort || i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_sh      <= '0;
      bx_sh     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_sh      <= i_data_a;
            bx_sh     <= i_sub ? ~i_data_b : i_data_b;
            carry_reg <= i_carry ^ i_sub;
            idx       <= '0;
            sum_reg   <= '0;
          end
        end
        RUN: begin
          if (!i_abort) begin
            a_sh      <= a_sh >> 8;
            bx_sh     <= bx_sh >> 8;
            sum_reg   <= sum_shift;
            carry_reg <= slice_cout;
            if (last_byte) begin
              // On the last step the slice holds the operand MSBs in bit 7.
              carry_out <= slice_cout;
              ovf       <= (a_sh[7] == bx_sh[7]) & (slice_sum[7] != a_sh[7]);
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready    = (state == IDLE);
  assign o_valid    = (state == DONE);
  assign o_busy     = (state == RUN);
  assign o_sum      = sum_reg;
  assign o_carry    = carry_out;
  assign o_overflow = ovf;
  assign o_state    = state;
endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Directed bench for byte_serial_add_ctrl: 32-bit instance for directed cases,
// 8-bit and 64-bit instances for a random sweep against a full-width reference.

module tb_byte_serial_add_ctrl;
  logic        clk;
  logic        rst;
  int          sel;
  logic        valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic        abort;
  logic        rdy;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  logic        v8, v32, v64;
  logic        r8, r32, r64, ov8, ov32, ov64, c8, c32, c64, f8, f32, f64, b8, b32, b64;
  logic [7:0]  s8;
  logic [31:0] s32;
  logic [63:0] s64;
  logic [1:0]  st8, st32, st64;

  logic        obs_ready, obs_valid, obs_carry, obs_ovf, obs_busy;
  logic [63:0] obs_sum;
  logic [1:0]  obs_state;

  assign v8  = valid && (sel == 8);
  assign v32 = valid && (sel == 32);
  assign v64 = valid && (sel == 64);

  byte_serial_add_ctrl #(.DATA_WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(r8),
    .i_data_a(a[7:0]), .i_data_b(b[7:0]), .i_carry(cin), .i_sub(sub),
    .i_abort(abort), .o_valid(ov8), .i_ready(rdy), .o_sum(s8),
    .o_carry(c8), .o_overflow(f8), .o_busy(b8), .o_state(st8)
  );

  byte_serial_add_ctrl #(.DATA_WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(r32),
    .i_data_a(a[31:0]), .i_data_b(b[31:0]), .i_carry(cin), .i_sub(sub),
    .i_abort(abort), .o_valid(ov32), .i_ready(rdy), .o_sum(s32),
    .o_carry(c32), .o_overflow(f32), .o_busy(b32), .o_state(st32)
  );

  byte_serial_add_ctrl #(.DATA_WIDTH(64)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_valid(v64), .o_ready(r64),
    .i_data_a(a), .i_data_b(b), .i_carry(cin), .i_sub(sub),
    .i_abort(abort), .o_valid(ov64), .i_ready(rdy), .o_sum(s64),
    .o_carry(c64), .o_overflow(f64), .o_busy(b64), .o_state(st64)
  );

  always_comb begin
    obs_ready = r32; obs_valid = ov32; obs_sum = {32'd0, s32};
    obs_carry = c32; obs_ovf = f32; obs_busy = b32; obs_state = st32;
    if (sel == 8) begin
      obs_ready = r8; obs_valid = ov8; obs_sum = {56'd0, s8};
      obs_carry = c8; obs_ovf = f8; obs_busy = b8; obs_state = st8;
    end else if (sel == 64) begin
      obs_ready = r64; obs_valid = ov64; obs_sum = s64;
      obs_carry = c64; obs_ovf = f64; obs_busy = b64; obs_state = st64;
    end
  end

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full-width reference: returns {overflow, carry, sum}.
  function automatic logic [65:0] model(input int w, input logic [63:0] aa, input logic [63:0] bb,
                                        input logic c, input logic s);
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bx;
    logic [64:0] full;
    logic [63:0] sm;
    logic        co;
    logic        ov;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = aa & mask;
    bx   = (s ? ~bb : bb) & mask;
    full = {1'b0, am} + {1'b0, bx} + {64'd0, c ^ s};
    sm   = full[63:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == bx[w-1]) && (sm[w-1] != am[w-1]);
    return {ov, co, sm};
  endfunction

  task automatic wait_valid(input int w, output int n, output int busy_n);
    n = 0;
    busy_n = obs_busy ? 1 : 0;
    while (!obs_valid && n < w / 8 + 4) begin
      tick();
      n++;
      if (obs_busy) busy_n++;
    end
  endtask

  task automatic handshake();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  task automatic run_op(input string tag, input int w, input logic [63:0] aa, input logic [63:0] bb,
                        input logic c, input logic s, input logic [63:0] es, input logic ec,
                        input logic ev);
    int n;
    int busy_n;
    logic [63:0] e;
    sel = w; a = aa; b = bb; cin = c; sub = s; valid = 1'b1;
    exp_q.push_back(es);
    #1;
    check({tag, " ready_before"}, {63'd0, obs_ready}, 64'd1);
    tick();
    valid = 1'b0;
    wait_valid(w, n, busy_n);
    e = exp_q.pop_front();
    check({tag, " latency"}, 64'(n), 64'(w / 8));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(w / 8));
    check({tag, " sum"}, obs_sum, e);
    check({tag, " carry"}, {63'd0, obs_carry}, {63'd0, ec});
    check({tag, " overflow"}, {63'd0, obs_ovf}, {63'd0, ev});
    handshake();
    check({tag, " valid_after_hs"}, {63'd0, obs_valid}, 64'd0);
  endtask

  initial begin
    int n;
    int busy_n;
    logic seen_valid;
    logic [65:0] m;
    logic [63:0] ra;
    logic [63:0] rb;
    logic rc;
    logic rs;

    sel = 32; valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; abort = 1'b0; rdy = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("reset ready", {63'd0, obs_ready}, 64'd1);
    check("reset valid", {63'd0, obs_valid}, 64'd0);
    check("reset busy", {63'd0, obs_busy}, 64'd0);
    check("reset sum", obs_sum, 64'd0);
    check("reset carry", {63'd0, obs_carry}, 64'd0);
    check("reset overflow", {63'd0, obs_ovf}, 64'd0);
    check("reset state", {62'd0, obs_state}, 64'd0);
    rst = 1'b0;
    tick();

    run_op("add_ff_1", 32, 64'h0000_00FF, 64'h1, 1'b0, 1'b0, 64'h0000_0100, 1'b0, 1'b0);
    run_op("add_chain", 32, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op("add_ovf", 32, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1);
    run_op("sub_5_7", 32, 64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_7_5_b", 32, 64'h7, 64'h5, 1'b1, 1'b1, 64'h1, 1'b1, 1'b0);

    // Backpressure, and a request held during RUN/DONE
    sel = 32; a = 64'h1234_5678; b = 64'h1111_1111; cin = 1'b0; sub = 1'b0; valid = 1'b1;
    tick();
    a = 64'h10; b = 64'h20;
    check("bp ready_in_run", {63'd0, obs_ready}, 64'd0);
    wait_valid(32, n, busy_n);
    check("bp latency", 64'(n), 64'd4);
    for (int i = 0; i < 3; i++) begin
      check("bp valid_hold", {63'd0, obs_valid}, 64'd1);
      check("bp sum_hold", obs_sum, 64'h2345_6789);
      check("bp carry_hold", {63'd0, obs_carry}, 64'd0);
      check("bp ready_in_done", {63'd0, obs_ready}, 64'd0);
      tick();
    end
    check("bp sum_final", obs_sum, 64'h2345_6789);
    handshake();
    check("bp ready_after_hs", {63'd0, obs_ready}, 64'd1);
    check("bp busy_after_hs", {63'd0, obs_busy}, 64'd0);
    tick();
    valid = 1'b0;
    check("bp second_accepted", {63'd0, obs_busy}, 64'd1);
    wait_valid(32, n, busy_n);
    check("bp second_sum", obs_sum, 64'h30);
    handshake();

    // Abort during byte 2
    a = 64'h0101_0101; b = 64'h0101_0101; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort2 ready", {63'd0, obs_ready}, 64'd1);
    check("abort2 valid", {63'd0, obs_valid}, 64'd0);
    check("abort2 busy", {63'd0, obs_busy}, 64'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs_valid) seen_valid = 1'b1;
    end
    check("abort2 no_valid", {63'd0, seen_valid}, 64'd0);
    run_op("after_abort", 32, 64'h1, 64'h2, 1'b0, 1'b0, 64'h3, 1'b0, 1'b0);

    // Abort together with the last byte: flags must keep the previous result's values
    a = 64'h8000_0000; b = 64'h8000_0000; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_last valid", {63'd0, obs_valid}, 64'd0);
    check("abort_last ready", {63'd0, obs_ready}, 64'd1);
    check("abort_last carry", {63'd0, obs_carry}, 64'd0);
    check("abort_last overflow", {63'd0, obs_ovf}, 64'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs_valid) seen_valid = 1'b1;
    end
    check("abort_last no_valid", {63'd0, seen_valid}, 64'd0);

    // Abort in DONE wins over i_ready
    valid = 1'b1;
    tick();
    valid = 1'b0;
    wait_valid(32, n, busy_n);
    check("done_abort sum", obs_sum, 64'h0);
    check("done_abort carry", {63'd0, obs_carry}, 64'd1);
    check("done_abort overflow", {63'd0, obs_ovf}, 64'd1);
    abort = 1'b1; rdy = 1'b1;
    tick();
    abort = 1'b0; rdy = 1'b0;
    check("done_abort valid", {63'd0, obs_valid}, 64'd0);
    check("done_abort ready", {63'd0, obs_ready}, 64'd1);

    // Reset mid-RUN
    a = 64'h0101_0101; b = 64'h0101_0101; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_run ready", {63'd0, obs_ready}, 64'd1);
    check("rst_run valid", {63'd0, obs_valid}, 64'd0);
    check("rst_run busy", {63'd0, obs_busy}, 64'd0);
    check("rst_run sum", obs_sum, 64'd0);
    check("rst_run carry", {63'd0, obs_carry}, 64'd0);
    check("rst_run overflow", {63'd0, obs_ovf}, 64'd0);

    // Abort in IDLE is ignored; the simultaneous request is accepted
    a = 64'h100; b = 64'h200; valid = 1'b1; abort = 1'b1;
    tick();
    valid = 1'b0; abort = 1'b0;
    check("idle_abort accepted", {63'd0, obs_busy}, 64'd1);
    wait_valid(32, n, busy_n);
    check("idle_abort sum", obs_sum, 64'h300);
    handshake();

    // Width sweep against the reference model
    for (int i = 0; i < 8; i++) begin
      ra = {56'd0, 8'($urandom_range(0, 255))};
      rb = {56'd0, 8'($urandom_range(0, 255))};
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      m = model(8, ra, rb, rc, rs);
      run_op("w8_rand", 8, ra, rb, rc, rs, m[63:0], m[64], m[65]);
    end
    run_op("w8_ovf", 8, 64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      m = model(64, ra, rb, rc, rs);
      run_op("w64_rand", 64, ra, rb, rc, rs, m[63:0], m[64], m[65]);
    end
    run_op("w64_chain", 64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/byte_serial_add_ctrl.md
Name: byte_serial_add_ctrl

Overview:
- Multi-cycle controller that time-shares a single CLA_8bit slice to add or subtract DATA_WIDTH-bit operands, one byte per cycle, LSB byte first.
- Carries the slice carry-out in a register between byte steps.
- Sits in the FPU_ADD path as a low-area alternative to a full-width mantissa/exponent adder.
- Valid/ready on both the request side and the result side.

Parameters:
- DATA_WIDTH, 32, operand and result width; must be a multiple of 8 and ≥8 (elaboration error otherwise).
- NUM_BYTES, DATA_WIDTH/8, number of byte steps (derived localparam, not overridable).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  request valid.
- o_ready  out  1  controller can accept a request (high only in IDLE).
- i_data_a  in  DATA_WIDTH  operand A.
- i_data_b  in  DATA_WIDTH  operand B.
- i_carry  in  1  carry-in (add) / borrow-in (sub).
- i_sub  in  1  0 = A+B+cin; 1 = A−B−borrow.
- i_abort  in  1  drop the operation in flight.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_sum  out  DATA_WIDTH  result.
- o_carry  out  1  raw carry out of MSB slice.
- o_overflow  out  1  signed two's-complement overflow.
- o_busy  out  1  state is RUN.

Behaviour:
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_sum=0, o_carry=0, o_overflow=0, byte index=0, carry reg=0.
- FSM: IDLE, RUN, DONE.
- IDLE:
  - Accept on i_valid & o_ready at a rising edge.
  - Latch A; latch Bx = i_sub ? ~i_data_b : i_data_b.
  - Latch carry reg = i_carry ^ i_sub; latch i_sub.
  - Byte index=0; clear the result register; go to RUN.
- RUN, one byte per cycle, for k = 0..NUM_BYTES−1:
  - Slice inputs: A[8k+7:8k], Bx[8k+7:8k], carry reg.
  - At the edge: result byte k ← slice sum; carry reg ← slice carry; k ← k+1.
  - After byte NUM_BYTES−1: go to DONE; o_carry ← slice carry; o_overflow ← (A[MSB]==Bx[MSB]) & (sum[MSB]!=A[MSB]).
- Latency: accept at edge E0; RUN occupies the NUM_BYTES cycles after E0; o_valid rises at edge E0+NUM_BYTES (5th cycle after accept for 32-bit).
- DONE:
  - o_valid=1; o_sum, o_carry and o_overflow held stable while i_ready=0.
  - On i_ready, go to IDLE. o_ready returns the following cycle, so there is one bubble and peak throughput is one op per NUM_BYTES+2 cycles.
- o_sum, o_carry and o_overflow keep their last value in IDLE. Only valid when o_valid=1.
- Sub semantics: o_carry=1 means no borrow.
- i_valid outside IDLE is ignored. No queueing; the requester must hold i_valid until o_ready.
- i_abort in RUN or DONE: go to IDLE next edge, o_valid=0, result discarded, o_carry and o_overflow not updated.
- Priority of i_abort:
  - Wins over completion on the last RUN byte.
  - Wins over i_ready in DONE.
  - Ignored in IDLE, where a simultaneous i_valid is accepted normally.
- i_rst wins over everything. Reset mid-RUN or mid-DONE returns all outputs to their reset values on the next edge.
- DATA_WIDTH=8: a single RUN cycle, with o_valid at E0+1.
- The byte index counter is sized $clog2(NUM_BYTES)+1 and never wraps past NUM_BYTES−1.

Test Plan:
- Add, 32-bit, A=0x000000FF, B=0x00000001, cin=0, sub=0 -> o_sum=0x00000100, o_carry=0, o_overflow=0; o_valid exactly 4 edges after accept; o_busy high 4 cycles.
- Carry chain across all bytes, A=0xFFFFFFFF, B=0x00000001 -> o_sum=0x00000000, o_carry=1, o_overflow=0. Also A=0x7FFFFFFF, B=1 -> 0x80000000, o_overflow=1, o_carry=0.
- Sub, A=0x00000005, B=0x00000007, borrow=0 -> o_sum=0xFFFFFFFE, o_carry=0. Also A=7, B=5, borrow=1 -> o_sum=0x00000001, o_carry=1.
- Backpressure: hold i_ready=0 for 3 cycles in DONE -> o_valid, o_sum and flags stable. A new i_valid during RUN/DONE is not accepted (o_ready=0) and is accepted in the cycle after the result handshake.
- Abort/reset: i_abort during byte 2 -> IDLE next cycle, o_valid never asserted, next op A=1, B=2 gives 3. i_abort and the last byte together -> no o_valid. i_rst mid-RUN -> all outputs at reset values, o_ready=1 next cycle.
- Parameter sweep with DATA_WIDTH=8 and 64, random A/B/i_carry/i_sub against a reference model -> o_sum, o_carry and o_overflow match; latency is NUM_BYTES edges.
